muldiv_unit: RTL

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It sits beside the main ALU in the EX stage and is selected by the ALU control decode when ALUOp=2'b10 and Funct is a HI/LO-class code. It executes mult, multu, div and divu over multiple cycles, and services mfhi, mflo, mthi and mtlo. While a result is pending it asserts a stall to the pipeline, replacing the old single-bit multu strobe and HI/LO read-select scheme.

---
 rtl/mips_defs.sv | 38 +++
 rtl/muldiv_iter.sv | 40 ++++
 rtl/muldiv_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mips_defs.sv
// Shared MIPS decode definitions: R-type function codes and the
// multiply/divide unit's FSM state encoding.
package mips_defs;

  // Existing ALU R-type function codes
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_ADDU  = 6'd33;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SUBU  = 6'd35;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_XOR   = 6'd38;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLTU  = 6'd43;

  // HI/LO-class function codes
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_CALC  = 2'd1,
    MD_FIXUP = 2'd2
  } md_state_e;

  // mult/multu/div/divu occupy 24..27: bit1 selects divide, bit0 selects unsigned
  function automatic logic is_muldiv(input logic [5:0] f);
    return (f[5:2] == 4'b0110);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 iteration of the multiply/divide datapath.
// Multiply: conditional add of the multiplicand, then shift {upper,lower} right.
// Divide: shift {upper,lower} left, trial-subtract the divisor, restore on borrow.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             op_div,
  input  logic [WIDTH:0]   upper,
  input  logic [WIDTH-1:0] lower,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH:0]   next_upper,
  output logic [WIDTH-1:0] next_lower
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  // Single step: add-shift or trial-subtract-shift
  always_comb begin
    next_upper = upper;
    next_lower = lower;
    sum        = lower[0] ? (upper + {1'b0, operand}) : upper;
    shifted    = {upper[WIDTH-1:0], lower[WIDTH-1]};
    trial      = {1'b0, shifted} - {2'b00, operand};
    if (op_div) begin
      if (!trial[WIDTH+1]) begin
        next_upper = trial[WIDTH:0];
        next_lower = {lower[WIDTH-2:0], 1'b1};
      end else begin
        next_upper = shifted;
        next_lower = {lower[WIDTH-2:0], 1'b0};
      end
    end else begin
      next_upper = {1'b0, sum[WIDTH:1]};
      next_lower = {sum[0], lower[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Handshake: start presents an instruction each cycle it is high; when stall
// is high the unit has not taken it and the pipeline must re-present it.
// mf/mt moves complete in the issue cycle; mult/div report completion on done.
module muldiv_unit
  import mips_defs::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH:0]   acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] operand_q;
  logic             op_div_q, neg_lo_q, neg_hi_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, illegal_q;

  // FSM control strobes
  logic load, step, fixup, dz_write, wr_hi, wr_lo, illegal_d;

  // Issue decode
  logic             md_ok, div_zero, op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign op_signed = ~funct[0];
  assign md_ok     = is_muldiv(funct) & (SIGNED_EN | funct[0]);
  assign div_zero  = funct[1] & (src_b == '0);
  assign a_neg     = op_signed & src_a[WIDTH-1];
  assign b_neg     = op_signed & src_b[WIDTH-1];
  assign mag_a     = a_neg ? -src_a : src_a;
  assign mag_b     = b_neg ? -src_b : src_b;

  // Iteration datapath
  logic [WIDTH:0]   step_hi;
  logic [WIDTH-1:0] step_lo;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .op_div     (op_div_q),
    .upper      (acc_hi_q),
    .lower      (acc_lo_q),
    .operand    (operand_q),
    .next_upper (step_hi),
    .next_lower (step_lo)
  );

  // Sign correction on the unsigned magnitude result
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

  assign prod     = {acc_hi_q[WIDTH-1:0], acc_lo_q};
  assign prod_fix = neg_lo_q ? -prod : prod;
  assign quo_fix  = neg_lo_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = neg_hi_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];
  assign fix_hi   = op_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign fix_lo   = op_div_q ? quo_fix : prod_fix[WIDTH-1:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MD_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and control strobes
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    fixup     = 1'b0;
    dz_write  = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          if (md_ok) begin
            if (div_zero) begin
              dz_write = 1'b1;
            end else begin
              load    = 1'b1;
              state_d = MD_CALC;
            end
          end else if (funct == F_MTHI) begin
            wr_hi = 1'b1;
          end else if (funct == F_MTLO) begin
            wr_lo = 1'b1;
          end else if (funct != F_MFHI && funct != F_MFLO) begin
            illegal_d = 1'b1;
          end
        end
      end
      MD_CALC: begin
        step = 1'b1;
        if (count_q == CNT_W'(WIDTH - 1)) state_d = MD_FIXUP;
      end
      MD_FIXUP: begin
        fixup   = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Operand latch, iteration accumulator and counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      operand_q <= '0;
      op_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
    end else if (load) begin
      count_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= funct[1] ? mag_a : mag_b;
      operand_q <= funct[1] ? mag_b : mag_a;
      op_div_q  <= funct[1];
      neg_lo_q  <= a_neg ^ b_neg;
      neg_hi_q  <= a_neg;
    end else if (step) begin
      count_q   <= count_q + CNT_W'(1);
      acc_hi_q  <= step_hi;
      acc_lo_q  <= step_lo;
    end
  end

  // Architectural HI/LO and completion pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= fixup | dz_write;
      illegal_q <= illegal_d;
      if (fixup) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end else if (dz_write) begin
        hi_q <= src_a;
        lo_q <= '1;
      end else begin
        if (wr_hi) hi_q <= src_a;
        if (wr_lo) lo_q <= src_a;
      end
    end
  end

  assign busy    = (state_q != MD_IDLE);
  assign stall   = start & busy;
  assign done    = done_q;
  assign illegal = illegal_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign result  = (funct == F_MFHI) ? hi_q : lo_q;

endmodule
